text_loader: RTL and testbench

- Upstream stage of the BWT text memory (mem1).
- Accepts a byte stream over a valid/ready handshake and writes it into the text storage at consecutive addresses from 0.
- Reports the final text length and overflow to the BWT core.
- Synthesizable replacement for file-based preloading of the text memory.

---
 rtl/text_loader.sv | 116 +++++++++++
 tb/tb_text_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_loader.sv
// Byte-stream loader for the BWT text memory: accepts valid/ready bytes and writes them from address 0.
// Optional '$' end-marker write after the last byte when TEXT_LOADER_SENTINEL_EN is defined.
module text_loader #(
    parameter int len_addr = 10,
    parameter int len_str  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                mem_wen,
    output logic [len_addr-1:0] mem_addr,
    output logic [7:0]          mem_din,
    output logic                busy,
    output logic                done,
    output logic [len_addr:0]   text_len,
    output logic                overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TERM, S_DONE} state_t;

`ifdef TEXT_LOADER_SENTINEL_EN
    localparam int unsigned CAP_I = len_str - 1;
`else
    localparam int unsigned CAP_I = len_str;
`endif
    localparam logic [len_addr:0] CAP = (len_addr+1)'(CAP_I);
    localparam logic [len_addr:0] ONE = (len_addr+1)'(1);

    state_t                r_state;
    logic [len_addr:0]     r_cnt;
    logic                  r_wen;
    logic [len_addr-1:0]   r_addr;
    logic [7:0]            r_din;
    logic                  r_done;
    logic [len_addr:0]     r_text_len;
    logic                  r_overflow;

    logic                  w_ready;
    logic                  w_accept;
    logic [len_addr:0]     w_cnt_inc;

    assign w_ready   = (r_state == S_LOAD) && (r_cnt < CAP);
    assign w_accept  = in_valid && w_ready;
    assign w_cnt_inc = r_cnt + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_done     <= 1'b0;
            r_text_len <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking default; any branch below that issues a write overrides it.
            r_wen <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_text_len <= '0;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_wen  <= 1'b1;
                        r_addr <= r_cnt[len_addr-1:0];
                        r_din  <= in_data;
                        r_cnt  <= w_cnt_inc;
                        // in_last on the final slot wins over overflow
                        if (in_last || (w_cnt_inc == CAP)) begin
                            r_overflow <= !in_last;
`ifdef TEXT_LOADER_SENTINEL_EN
                            r_state    <= S_TERM;
`else
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_text_len <= w_cnt_inc;
`endif
                        end
                    end
                end
`ifdef TEXT_LOADER_SENTINEL_EN
                S_TERM: begin
                    r_wen      <= 1'b1;
                    r_addr     <= r_cnt[len_addr-1:0];
                    r_din      <= 8'h24;
                    r_text_len <= w_cnt_inc;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = w_ready;
    assign busy     = (r_state == S_LOAD) || (r_state == S_TERM);
    assign mem_wen  = r_wen;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign done     = r_done;
    assign text_len = r_text_len;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_text_loader.sv
// Directed bench for text_loader (len_str=8); expectations follow TEXT_LOADER_SENTINEL_EN.
module tb_text_loader;

    localparam int LEN_ADDR = 3;
    localparam int LEN_STR  = 8;
`ifdef TEXT_LOADER_SENTINEL_EN
    localparam int SENT = 1;
`else
    localparam int SENT = 0;
`endif
    localparam int CAP = LEN_STR - SENT;

    typedef struct { logic [LEN_ADDR-1:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic [7:0] data; int cyc; } acc_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic [7:0]          in_data = 8'h00;
    logic                in_last = 1'b0;
    logic                in_ready;
    logic                mem_wen;
    logic [LEN_ADDR-1:0] mem_addr;
    logic [7:0]          mem_din;
    logic                busy;
    logic                done;
    logic [LEN_ADDR:0]   text_len;
    logic                overflow;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   fed = 0;
    logic [7:0] stim [16];
    wr_t  wr_q [$];
    acc_t acc_q [$];

    text_loader #(.len_addr(LEN_ADDR), .len_str(LEN_STR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .busy(busy), .done(done), .text_len(text_len), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write and accept logs, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_wen === 1'b1) wr_q.push_back('{mem_addr, mem_din, cyc});
        if (in_valid === 1'b1 && in_ready === 1'b1) acc_q.push_back('{in_data, cyc});
    end

    task automatic load_str(input string s);
        for (int i = 0; i < 16; i++) stim[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        acc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input int last_idx, input bit gap);
        int i;
        int c;
        bit fire;
        i = first;
        c = 0;
        while (i < n && busy === 1'b1 && c < 100) begin
            in_valid = gap ? (c % 2 == 0) : 1'b1;
            in_data  = stim[i];
            in_last  = (i == last_idx);
            @(negedge clk);
            fire = (in_valid === 1'b1) && (in_ready === 1'b1);
            @(posedge clk); #1;
            if (fire) i++;
            c++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        fed = i;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 20 && done !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_timeout: done=%b want 1", name, done);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({in_ready, mem_wen, busy, done, overflow} !== 5'b0 || mem_addr !== '0 ||
            mem_din !== 8'h00 || text_len !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b wen=%b busy=%b done=%b ovf=%b addr=%h din=%h len=%0d want all 0",
                     in_ready, mem_wen, busy, done, overflow, mem_addr, mem_din, text_len);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_banana(input bit gap, input string name);
        logic [7:0] want;
        clear_logs();
        load_str("banana");
        pulse_start();
        feed(0, 6, 5, gap);
        wait_done(name);
        vectors++;
        if (fed !== 6) begin
            miscompares++;
            $display("FAIL %s_accepted: got %0d want 6", name, fed);
        end
        vectors++;
        if (text_len !== 4'(6 + SENT) || overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_status: len=%0d ovf=%b busy=%b rdy=%b want len=%0d ovf=0 busy=0 rdy=0",
                     name, text_len, overflow, busy, in_ready, 6 + SENT);
        end
        vectors++;
        if (wr_q.size() != 6 + SENT) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d want %0d", name, wr_q.size(), 6 + SENT);
        end
        for (int k = 0; k < 6 + SENT && k < wr_q.size(); k++) begin
            want = (k < 6) ? stim[k] : 8'h24;
            vectors++;
            if (wr_q[k].addr !== 3'(k) || wr_q[k].data !== want) begin
                miscompares++;
                $display("FAIL %s_write[%0d]: got %h@%0d want %h@%0d", name, k, wr_q[k].data, wr_q[k].addr, want, k);
            end
        end
        for (int k = 0; k < acc_q.size() && k < wr_q.size(); k++) begin
            vectors++;
            if (wr_q[k].cyc !== acc_q[k].cyc + 1) begin
                miscompares++;
                $display("FAIL %s_latency[%0d]: write cycle %0d want %0d", name, k, wr_q[k].cyc, acc_q[k].cyc + 1);
            end
        end
    endtask

    task automatic test_capacity(input int n, input int last_idx, input bit exp_ovf, input string name);
        logic [7:0] want;
        clear_logs();
        load_str("0123456789");
        pulse_start();
        feed(0, n, last_idx, 1'b0);
        wait_done(name);
        vectors++;
        if (fed !== CAP) begin
            miscompares++;
            $display("FAIL %s_accepted: got %0d want %0d", name, fed, CAP);
        end
        vectors++;
        if (overflow !== exp_ovf || text_len !== 4'(LEN_STR) || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_status: ovf=%b len=%0d rdy=%b want ovf=%b len=%0d rdy=0",
                     name, overflow, text_len, in_ready, exp_ovf, LEN_STR);
        end
        vectors++;
        if (wr_q.size() != LEN_STR) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d want %0d", name, wr_q.size(), LEN_STR);
        end
        for (int k = 0; k < LEN_STR && k < wr_q.size(); k++) begin
            want = (k < CAP) ? stim[k] : 8'h24;
            vectors++;
            if (wr_q[k].addr !== 3'(k) || wr_q[k].data !== want) begin
                miscompares++;
                $display("FAIL %s_write[%0d]: got %h@%0d want %h@%0d", name, k, wr_q[k].data, wr_q[k].addr, want, k);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        load_str("xyzw");
        pulse_start();
        feed(0, 3, -1, 1'b0);
        vectors++;
        if (mem_wen !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midload_pre_reset: wen=%b busy=%b want 1 1", mem_wen, busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_wen !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_async_reset: wen=%b busy=%b rdy=%b want 0 0 0", mem_wen, busy, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        load_str("ab");
        pulse_start();
        feed(0, 2, 1, 1'b0);
        wait_done("midload_reload");
        vectors++;
        if (text_len !== 4'(2 + SENT) || wr_q.size() != 2 + SENT) begin
            miscompares++;
            $display("FAIL midload_reload_len: len=%0d writes=%0d want %0d %0d", text_len, wr_q.size(), 2 + SENT, 2 + SENT);
        end
        vectors++;
        if (wr_q.size() < 2 || wr_q[0].addr !== 3'd0 || wr_q[0].data !== 8'h61 ||
            wr_q[1].addr !== 3'd1 || wr_q[1].data !== 8'h62) begin
            miscompares++;
            $display("FAIL midload_reload_data: first writes differ from 61@0 62@1 (count %0d)", wr_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        clear_logs();
        load_str("qrst");
        pulse_start();
        feed(0, 2, -1, 1'b0);
        pulse_start();
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start_state: busy=%b done=%b rdy=%b want 1 0 1", busy, done, in_ready);
        end
        feed(2, 4, 3, 1'b0);
        wait_done("busy_start");
        vectors++;
        if (text_len !== 4'(4 + SENT) || wr_q.size() != 4 + SENT) begin
            miscompares++;
            $display("FAIL busy_start_len: len=%0d writes=%0d want %0d %0d", text_len, wr_q.size(), 4 + SENT, 4 + SENT);
        end
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            vectors++;
            if (wr_q[k].addr !== 3'(k) || wr_q[k].data !== stim[k]) begin
                miscompares++;
                $display("FAIL busy_start_write[%0d]: got %h@%0d want %h@%0d", k, wr_q[k].data, wr_q[k].addr, stim[k], k);
            end
        end
        pulse_start();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 || text_len !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_from_done: done=%b busy=%b len=%0d ovf=%b want 0 1 0 0", done, busy, text_len, overflow);
        end
        clear_logs();
        feed(0, 2, 1, 1'b0);
        wait_done("restart");
        vectors++;
        if (wr_q.size() != 2 + SENT || wr_q[0].addr !== 3'd0 || wr_q[0].data !== stim[0] ||
            text_len !== 4'(2 + SENT)) begin
            miscompares++;
            $display("FAIL restart_load: writes=%0d len=%0d want %0d writes from addr 0, len %0d",
                     wr_q.size(), text_len, 2 + SENT, 2 + SENT);
        end
    endtask

    initial begin
        test_reset();
        test_banana(1'b0, "banana");
        test_banana(1'b1, "banana_gaps");
        test_capacity(10, -1, 1'b1, "overflow");
        test_capacity(CAP, CAP - 1, 1'b0, "exact_cap");
        test_reset_mid_load();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
